// File: rtl/pattern_sequencer_if.sv
// Pattern write bus for pattern_sequencer.
// The master side edits hit/accent cells; the sequencer is the slave.
interface pattern_sequencer_if #(
    parameter int CHANNELS = 4,
    parameter int STEPS    = 16
);
    localparam int SW = $clog2(STEPS);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic          wr_en;
    logic [CW-1:0] wr_chan;
    logic [SW-1:0] wr_step;
    logic          wr_hit;
    logic          wr_accent;

    modport master (
        output wr_en, wr_chan, wr_step, wr_hit, wr_accent
    );

    modport slave (
        input wr_en, wr_chan, wr_step, wr_hit, wr_accent
    );
endinterface

// File: rtl/pattern_sequencer.sv
// Multi-channel step sequencer: plays one pattern column per advance
// pulse and issues registered one-tick trigger/accent pulses per voice.
module pattern_sequencer #(
    parameter int CHANNELS = 4,
    parameter int STEPS    = 16,
    parameter logic [CHANNELS*STEPS-1:0] DEFAULT_HITS    = '0,
    parameter logic [CHANNELS*STEPS-1:0] DEFAULT_ACCENTS = '0,
    localparam int SW = $clog2(STEPS)
) (
    input  logic                audio_tick,
    input  logic                reset,
    input  logic                advance,
    input  logic                run,
    input  logic                restart,
    input  logic [SW-1:0]       last_step,
    input  logic [CHANNELS-1:0] mute,
    pattern_sequencer_if.slave  wr,
    output logic [CHANNELS-1:0] trigger,
    output logic [CHANNELS-1:0] accent,
    output logic [SW-1:0]       step,
    output logic                bar_start
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [STEPS-1:0]    hit_mem [CHANNELS];
    logic [STEPS-1:0]    acc_mem [CHANNELS];
    logic                play;
    logic [SW-1:0]       p;
    logic [CHANNELS-1:0] hit_col;
    logic [CHANNELS-1:0] acc_col;

    // A shortened length wraps straight to step 0 instead of running on.
    always_comb begin
        play = advance & run;
        p    = (restart || step > last_step) ? '0 : step;
        hit_col = '0;
        acc_col = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hit_col[c] = hit_mem[c][p];
            acc_col[c] = acc_mem[c][p];
        end
    end

    always_ff @(posedge audio_tick) begin
        if (reset) begin
            step      <= '0;
            trigger   <= '0;
            accent    <= '0;
            bar_start <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                hit_mem[c] <= DEFAULT_HITS[c*STEPS +: STEPS];
                acc_mem[c] <= DEFAULT_ACCENTS[c*STEPS +: STEPS];
            end
        end else begin
            if (play) begin
                trigger   <= hit_col & ~mute;
                accent    <= acc_col & hit_col & ~mute;
                bar_start <= (p == '0);
                step      <= (p >= last_step) ? '0 : p + SW'(1);
            end else begin
                trigger   <= '0;
                accent    <= '0;
                bar_start <= 1'b0;
                if (restart)
                    step <= '0;
            end
            // Channel numbers past CHANNELS match no row and are dropped.
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr.wr_en && wr.wr_chan == CW'(c)) begin
                    hit_mem[c][wr.wr_step] <= wr.wr_hit;
                    acc_mem[c][wr.wr_step] <= wr.wr_accent;
                end
            end
        end
    end
endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios plus random traffic,
// every tick compared against a cell-array reference of the sequencer.
module tb_pattern_sequencer;
    localparam int CH = 4;
    localparam int ST = 16;
    localparam logic [CH*ST-1:0] DEF_HITS = 64'h0000_0000_0000_5555;
    localparam logic [CH*ST-1:0] DEF_ACCS = '0;

    logic          audio_tick = 1'b0;
    logic          reset = 1'b1;
    logic          advance = 1'b0;
    logic          run = 1'b0;
    logic          restart = 1'b0;
    logic [3:0]    last_step = 4'd15;
    logic [CH-1:0] mute = '0;
    logic [CH-1:0] trigger;
    logic [CH-1:0] accent;
    logic [3:0]    step;
    logic          bar_start;

    pattern_sequencer_if #(.CHANNELS(CH), .STEPS(ST)) wr_bus ();

    pattern_sequencer #(
        .CHANNELS(CH), .STEPS(ST),
        .DEFAULT_HITS(DEF_HITS), .DEFAULT_ACCENTS(DEF_ACCS)
    ) dut (
        .audio_tick(audio_tick), .reset(reset), .advance(advance),
        .run(run), .restart(restart), .last_step(last_step),
        .mute(mute), .wr(wr_bus.slave), .trigger(trigger),
        .accent(accent), .step(step), .bar_start(bar_start)
    );

    always #5 audio_tick = ~audio_tick;

    int m_hit [CH][ST];
    int m_acc [CH][ST];
    int m_step;
    int e_trig, e_acc, e_bar;
    int total, passed, failed;

    // Reset pattern: channel 0 hits on every even step, nothing else.
    task automatic load_defaults();
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < ST; s++) begin
                m_hit[c][s] = (c == 0 && s % 2 == 0) ? 1 : 0;
                m_acc[c][s] = 0;
            end
    endtask

    task automatic model_edge();
        int p;
        int ls;
        ls = int'(last_step);
        e_trig = 0;
        e_acc = 0;
        e_bar = 0;
        if (reset) begin
            m_step = 0;
            load_defaults();
            return;
        end
        if (advance && run) begin
            p = (restart || m_step > ls) ? 0 : m_step;
            for (int c = 0; c < CH; c++)
                if (m_hit[c][p] != 0 && !mute[c]) begin
                    e_trig |= (1 << c);
                    if (m_acc[c][p] != 0) e_acc |= (1 << c);
                end
            e_bar = (p == 0) ? 1 : 0;
            m_step = (p >= ls) ? 0 : p + 1;
        end else if (restart) begin
            m_step = 0;
        end
        if (wr_bus.wr_en && int'(wr_bus.wr_chan) < CH) begin
            m_hit[wr_bus.wr_chan][wr_bus.wr_step] = int'(wr_bus.wr_hit);
            m_acc[wr_bus.wr_chan][wr_bus.wr_step] = int'(wr_bus.wr_accent);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h",
                   tag, $time, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge audio_tick);
        model_edge();
        #1;
        chk("trigger", int'(trigger), e_trig);
        chk("accent", int'(accent), e_acc);
        chk("bar_start", int'(bar_start), e_bar);
        chk("step", int'(step), m_step);
        advance = 1'b0;
        restart = 1'b0;
        reset = 1'b0;
        wr_bus.wr_en = 1'b0;
    endtask

    task automatic play_n(input int n, input int gap);
        repeat (n) begin
            advance = 1'b1;
            tick();
            repeat (gap) tick();
        end
    endtask

    task automatic write_cell(input int c, input int s,
                              input bit h, input bit a);
        wr_bus.wr_en = 1'b1;
        wr_bus.wr_chan = 2'(c);
        wr_bus.wr_step = 4'(s);
        wr_bus.wr_hit = h;
        wr_bus.wr_accent = a;
        tick();
    endtask

    task automatic seek(input int target);
        for (int i = 0; i < 40 && m_step != target; i++) begin
            advance = 1'b1;
            tick();
        end
        chk("seek", m_step, target);
    endtask

    initial begin
        total = 0;
        passed = 0;
        failed = 0;
        m_step = 0;
        load_defaults();
        wr_bus.wr_en = 1'b0;
        wr_bus.wr_chan = '0;
        wr_bus.wr_step = '0;
        wr_bus.wr_hit = 1'b0;
        wr_bus.wr_accent = 1'b0;

        reset = 1'b1;
        tick();
        reset = 1'b1;
        tick();

        // Default pattern over two full bars, advances 4 ticks apart.
        run = 1'b1;
        last_step = 4'd15;
        play_n(32, 3);

        // Hit+accent write, then hit cleared with accent still set.
        write_cell(2, 3, 1'b1, 1'b1);
        play_n(16, 0);
        write_cell(2, 3, 1'b0, 1'b1);
        play_n(16, 0);

        // Write and play of the same cell on one edge.
        seek(5);
        advance = 1'b1;
        wr_bus.wr_en = 1'b1;
        wr_bus.wr_chan = 2'd1;
        wr_bus.wr_step = 4'd5;
        wr_bus.wr_hit = 1'b1;
        wr_bus.wr_accent = 1'b0;
        tick();
        play_n(16, 0);

        // Shorten the length while beyond the new end.
        seek(10);
        last_step = 4'd7;
        play_n(10, 0);
        last_step = 4'd0;
        play_n(5, 1);
        last_step = 4'd15;

        // Stopped, restart with advance, bare restart.
        seek(4);
        run = 1'b0;
        play_n(5, 1);
        run = 1'b1;
        seek(9);
        restart = 1'b1;
        advance = 1'b1;
        tick();
        play_n(2, 0);
        restart = 1'b1;
        tick();
        tick();

        // Mute with every cell set.
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < ST; s++)
                write_cell(c, s, 1'b1, (s % 3 == 0));
        mute = 4'b1010;
        play_n(4, 1);
        mute = 4'b0000;
        play_n(4, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            advance = ($urandom_range(0, 2) != 0);
            run = ($urandom_range(0, 7) != 0);
            restart = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0)
                last_step = 4'($urandom_range(0, 15));
            mute = 4'($urandom);
            wr_bus.wr_en = ($urandom_range(0, 2) == 0);
            wr_bus.wr_chan = 2'($urandom);
            wr_bus.wr_step = 4'($urandom);
            wr_bus.wr_hit = 1'($urandom);
            wr_bus.wr_accent = 1'($urandom);
            tick();
        end

        // Overwrite, then reset together with advance mid-sequence.
        run = 1'b1;
        last_step = 4'd15;
        mute = '0;
        for (int s = 0; s < ST; s++) begin
            write_cell(0, s, 1'b0, 1'b0);
            write_cell(3, s, 1'b1, 1'b1);
        end
        seek(6);
        reset = 1'b1;
        advance = 1'b1;
        tick();
        play_n(20, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Multi-channel, programmable step sequencer that generates per-channel one-tick trigger pulses in the drum machine's audio-tick domain. It holds a runtime-writable pattern of hit and accent bits, and it advances one step per `advance` pulse from the tempo generator. The sequence length is programmable, and the block provides per-channel mute, run/stop and restart. Its triggers and accents drive the voice generators, one channel per voice.

## Interface

Parameters:
- `CHANNELS`, 4: number of voices; ≥1.
- `STEPS`, 16: pattern depth; power of two, ≥2. `SW = $clog2(STEPS)`.
- `DEFAULT_HITS`, `{CHANNELS*STEPS{1'b0}}`: reset hit pattern; bit `c*STEPS+s` is channel c, step s.
- `DEFAULT_ACCENTS`, `{CHANNELS*STEPS{1'b0}}`: reset accent pattern; same indexing.

Ports (one clock; reset is synchronous and active-high):
- `audio_tick` in 1: sole clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `advance` in 1: one-tick step pulse.
- `run` in 1: 1 = sequencing enabled.
- `restart` in 1: one-tick pulse; next played step is 0.
- `last_step` in SW: index of final step; the sequence length is `last_step+1`.
- `mute` in CHANNELS: per-channel trigger suppression.
- `wr_en` in 1: pattern write strobe.
- `wr_chan` in `$clog2(CHANNELS)` (min 1): write channel.
- `wr_step` in SW: write step.
- `wr_hit` in 1: hit bit to write.
- `wr_accent` in 1: accent bit to write.
- `trigger` out CHANNELS: one-tick hit pulses.
- `accent` out CHANNELS: accent flag, valid only while the matching `trigger` bit is high.
- `step` out SW: index of the next step to play.
- `bar_start` out 1: one-tick pulse when step 0 is played.

## Operation

- Reset (`reset`=1 at the edge):
  - `step`=0; `trigger`, `accent` and `bar_start` are 0.
  - Pattern reloads `DEFAULT_HITS` and `DEFAULT_ACCENTS`.
  - Reset overrides every other input.
- Play step `p`. This happens on any edge where `advance & run`, with `p` chosen as follows:
  - If `restart`=1, then p=0.
  - Else if `step > last_step` (the length was shortened), then p=0.
  - Else p=`step`.
- On a play edge:
  - `trigger[c] <= hit[c][p] & ~mute[c]`.
  - `accent[c] <= accent_bit[c][p] & hit[c][p] & ~mute[c]`.
  - `bar_start <= (p==0)`.
  - `step <= (p >= last_step) ? 0 : p+1`.
- Non-play edges:
  - `trigger`, `accent` and `bar_start` go to 0.
  - If `restart`=1, then `step <= 0`; otherwise `step` holds.
  - `run`=0 freezes `step`; `advance` is ignored.
- Pattern write: on an edge with `wr_en`=1, `hit[wr_chan][wr_step] <= wr_hit` and `accent_bit[wr_chan][wr_step] <= wr_accent`.
  - If `wr_chan >= CHANNELS`, the write is ignored.
  - A write and a play of the same cell on the same edge: the play uses the old value; the new value takes effect from the next play.
- Mute is sampled at the play edge only; changing it never truncates a pulse already issued.
- `last_step` is sampled every play edge; the length may change at any time with no glitch beyond the wrap rule above.
- With `last_step`=0, every play is step 0: `bar_start` pulses on every play and `step` stays 0.

## Timing

- Latency: `trigger`, `accent` and `bar_start` are registered, high for exactly the one tick after the play edge.
- Back-to-back `advance` pulses on consecutive ticks are legal and give consecutive pulses with no gap.
- `step` updates on the same edge that registers the trigger.
- No combinational path from any input to any output.
- Reset mid-sequence: the next tick shows all outputs 0 and `step`=0; the first subsequent play is step 0.

## Test plan

- Reset defaults:
  - Stimulus: CHANNELS=4, STEPS=16, DEFAULT_HITS with ch0 = 0x5555 (steps 0,2,4,…); `run`=1, `last_step`=15; 32 `advance` pulses spaced 4 ticks apart.
  - Required: `trigger[0]` high on plays 0,2,…,30; `bar_start` on plays 0 and 16; `step` wraps 15→0.
- Write/accent:
  - Stimulus: write ch2, step 3, hit=1, accent=1; write ch2, step 3 again with hit=0, accent=1.
  - Required after the first write: the play of step 3 gives `trigger[2]`=1, `accent[2]`=1. After the second write: `trigger[2]`=0 and `accent[2]`=0 (accent is masked by hit).
  - Collision: write ch1, step 5 hit=1 on the same edge that plays step 5 → no trigger that play; trigger on the next pass of step 5.
- Length change:
  - Stimulus: with `step`=10, set `last_step`=7 and advance.
  - Required: step 0 is played with `bar_start`=1, then `step`=1. With `last_step`=0: every play is step 0.
- Run/restart:
  - `run`=0 with 5 `advance` pulses → no triggers; `step` unchanged.
  - `restart` and `advance` together at `step`=9 → step 0 played, `step`=1.
  - `restart` alone → `step`=0, no trigger.
- Mute:
  - Stimulus: all hits set, `mute`=4'b1010.
  - Required: only `trigger[0]` and `trigger[2]` pulse; clearing mute restores ch1 and ch3 on the next play.
- Reset mid-operation:
  - Stimulus: assert `reset` for 1 tick on the same edge as `advance`, after overwriting patterns.
  - Required: no trigger; `step`=0; pattern back to defaults. The next play is step 0.
